dcache_wbuf: RTL and testbench
==============================

DCACHE_WBUF -- requirements
Module: dcache_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of dirty-line entries (power of 2, >=2).
REQ-002 SHALL have parameter LINE_W, default 256, cacheline width in bits (8 x 32-bit words, `WayBus).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port push_valid  in  1  dcache offers an evicted dirty line.
REQ-006 SHALL have port push_ready  out  1  buffer accepts the offered line this cycle.
REQ-007 SHALL have port push_addr  in  32  line address; bits [4:0] ignored.
REQ-008 SHALL have port push_data  in  LINE_W  line data, word 0 in [31:0].
REQ-009 SHALL have port lookup_addr  in  32  dcache miss address for forwarding check.
REQ-010 SHALL have port lookup_hit  out  1  a valid entry holds the line of lookup_addr; combinational.
REQ-011 SHALL have port lookup_data  out  LINE_W  data of the hitting entry; combinational; zero when no hit.
REQ-012 SHALL have port bridge_idle_i  in  1  AXI bridge is in IDLE/READ_END/WRITE_END and has no request this cycle.
REQ-013 SHALL have port ca_wreq_o  out  1  one-cycle burst-write request to the bridge.
REQ-014 SHALL have port wb_addr_o  out  32  {head addr[31:5],5'b0}, valid from ca_wreq_o until axi_wend_i.
REQ-015 SHALL have port wb_data_o  out  LINE_W  head line data, held stable from ca_wreq_o until axi_wend_i.
REQ-016 SHALL have port axi_wend_i  in  1  bridge write-complete pulse (bvalid).
REQ-017 SHALL have ports empty and full  out  1 each  count==0 and count==DEPTH.

Function
REQ-018 SHALL store entries in a circular FIFO with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-019 SHALL drive push_ready = !full, from registered count only; a same-cycle pop SHALL NOT raise push_ready.
REQ-020 SHALL, on push_valid&push_ready with no merge hit, write addr/data at tail, set valid, advance tail and increment count at the next edge.
REQ-021 SHALL, when push_addr[31:5] matches a valid entry not in flight, overwrite that entry's data in place with count unchanged; such a merge SHALL be accepted even when full (push_ready=1 in that case).
REQ-022 SHALL, when push_addr matches only the in-flight head, allocate a new tail entry per REQ-020.
REQ-023 SHALL run drain FSM states IDLE and WAIT; IDLE->WAIT when !empty & bridge_idle_i, with ca_wreq_o=1 for exactly that cycle; WAIT->IDLE on axi_wend_i.
REQ-024 SHALL, on axi_wend_i in WAIT, invalidate head, advance head and decrement count at the same edge; axi_wend_i in IDLE SHALL be ignored.
REQ-025 SHALL, on simultaneous push and pop, net count unchanged (count==1 stays 1, tail and head both advance).
REQ-026 SHALL compute lookup over all valid entries including the in-flight head; on multiple matches the youngest entry wins.
REQ-027 SHALL not re-request while in WAIT; minimum spacing between ca_wreq_o pulses is 2 cycles.

Reset
REQ-028 SHALL, while rst=1, clear all valid bits, head, tail, count, FSM to IDLE; outputs: push_ready=1, empty=1, full=0, ca_wreq_o=0, lookup_hit=0, lookup_data=0, wb_addr_o=0, wb_data_o=0.
REQ-029 SHALL, on rst mid-WAIT, discard the in-flight entry; the bridge is reset on the same signal by integration.

Verification
REQ-030 SHALL test: push 0x1000_0040 data D0, bridge_idle_i=1 -> ca_wreq_o pulses 1 cycle at cycle+1, wb_addr_o=0x1000_0040; axi_wend_i -> empty=1 next cycle.
REQ-031 SHALL test: bridge_idle_i=0, push 2 lines -> full=1, push_ready=0; third distinct push held until axi_wend_i retires head.
REQ-032 SHALL test: full, push of address matching tail entry with D2 -> accepted, count stays 2, lookup of that address returns D2.
REQ-033 SHALL test: count=1 in WAIT, push and axi_wend_i same cycle -> count=1, new line becomes head, second ca_wreq_o issued with its address.
REQ-034 SHALL test: lookup_addr=0x1000_005C while entry 0x1000_0040 in flight -> lookup_hit=1, data=D0; after axi_wend_i -> lookup_hit=0.
REQ-035 SHALL test: rst asserted during WAIT with 2 entries -> next cycle empty=1, ca_wreq_o=0, lookup_hit=0, later axi_wend_i ignored.

Source files
------------

// File: rtl/dcache_wbuf.sv
// dcache_wbuf: dirty-line write buffer between the dcache and the AXI bridge.
// Merges re-evicted lines, forwards data to misses, drains one line at a time.
module dcache_wbuf #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [31:0]       push_addr,
    input  logic [LINE_W-1:0] push_data,
    input  logic [31:0]       lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    input  logic              bridge_idle_i,
    output logic              ca_wreq_o,
    output logic [31:0]       wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o,
    input  logic              axi_wend_i,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic { S_IDLE, S_WAIT } state_t;

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [26:0]       addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    ptr_t              head_q, tail_q;
    logic [PW:0]       count_q;

    logic merge_hit;
    ptr_t merge_idx;
    ptr_t hit_idx;
    logic alloc, merge_we, pop, in_flight;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{push_addr[4:0], lookup_addr[4:0]};

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign in_flight  = (state_q == S_WAIT);
    assign push_ready = !full || merge_hit;
    assign alloc      = push_valid && push_ready && !merge_hit;
    assign merge_we   = push_valid && merge_hit;
    assign pop        = in_flight && axi_wend_i;

    // Find a resident copy of the pushed line that is safe to overwrite.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == push_addr[31:5] &&
                !(in_flight && ptr_t'(i) == head_q)) begin
                merge_hit = 1'b1;
                merge_idx = ptr_t'(i);
            end
        end
    end

    // Forwarding lookup, oldest to youngest so the youngest match wins.
    always_comb begin
        lookup_hit = 1'b0;
        hit_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[ptr_t'(head_q + ptr_t'(k))] &&
                addr_q[ptr_t'(head_q + ptr_t'(k))] == lookup_addr[31:5]) begin
                lookup_hit = 1'b1;
                hit_idx    = ptr_t'(head_q + ptr_t'(k));
            end
        end
        lookup_data = lookup_hit ? data_q[hit_idx] : '0;
    end

    // Head line as seen by the bridge; stable in WAIT since merges skip it.
    always_comb begin
        wb_addr_o = '0;
        wb_data_o = '0;
        if (valid_q[head_q]) begin
            wb_addr_o = {addr_q[head_q], 5'b0};
            wb_data_o = data_q[head_q];
        end
    end

    // Line storage: allocate at tail or merge in place.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= push_addr[31:5];
            data_q[tail_q] <= push_data;
        end else if (merge_we) begin
            data_q[merge_idx] <= push_data;
        end
    end

    // Valid bits, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ptr_t'(1);
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + ptr_t'(1);
            end
            if (alloc && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !alloc)
                count_q <= count_q - 1'b1;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Drain FSM: request once, then wait for the write response.
    always_comb begin
        state_d   = state_q;
        ca_wreq_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && bridge_idle_i) begin
                    ca_wreq_o = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (axi_wend_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_wbuf.sv
// tb_dcache_wbuf: directed vector bench for the dcache write buffer.
// One vector per cycle; outputs checked mid-cycle before the next edge.
module tb_dcache_wbuf;

    localparam int LW = 256;

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A5C = 32'h1000_005C;
    localparam logic [31:0] A1 = 32'h1000_0080;
    localparam logic [31:0] A2 = 32'h1000_00C0;
    localparam logic [31:0] A3 = 32'h1000_0100;
    localparam logic [31:0] D0 = 32'hA000_0000;
    localparam logic [31:0] D1 = 32'hA100_0000;
    localparam logic [31:0] D2 = 32'hA200_0000;
    localparam logic [31:0] D3 = 32'hA300_0000;
    localparam logic [31:0] D4 = 32'hA400_0000;
    localparam logic [31:0] D5 = 32'hA500_0000;
    localparam logic [31:0] D6 = 32'hA600_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_addr;
    logic [LW-1:0] push_data;
    logic [31:0]   lookup_addr;
    logic          lookup_hit;
    logic [LW-1:0] lookup_data;
    logic          bridge_idle_i;
    logic          ca_wreq_o;
    logic [31:0]   wb_addr_o;
    logic [LW-1:0] wb_data_o;
    logic          axi_wend_i;
    logic          empty;
    logic          full;

    int n_chk  = 0;
    int n_fail = 0;

    dcache_wbuf #(.DEPTH(2), .LINE_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_addr     (push_addr),
        .push_data     (push_data),
        .lookup_addr   (lookup_addr),
        .lookup_hit    (lookup_hit),
        .lookup_data   (lookup_data),
        .bridge_idle_i (bridge_idle_i),
        .ca_wreq_o     (ca_wreq_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .axi_wend_i    (axi_wend_i),
        .empty         (empty),
        .full          (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] paddr;
        logic [31:0] ptag;
        logic [31:0] laddr;
        logic        bidle;
        logic        wend;
        logic        e_ready;
        logic        e_hit;
        logic [31:0] e_ltag;
        logic        e_wreq;
        logic        e_empty;
        logic        e_full;
        logic [31:0] e_wbaddr;
        logic [31:0] e_wbtag;
    } vec_t;

    vec_t vecs[$];

    // Line with word i = tag | i; tag 0 stands for an all-zero line.
    function automatic logic [LW-1:0] mkline(input logic [31:0] tag);
        logic [LW-1:0] l;
        l = '0;
        if (tag != 0)
            for (int i = 0; i < LW / 32; i++)
                l[i*32 +: 32] = tag | 32'(i);
        return l;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [31:0] pa,
                       input logic [31:0] pt, input logic [31:0] la,
                       input logic bi, input logic we,
                       input logic rdy, input logic hit,
                       input logic [31:0] lt, input logic wr,
                       input logic em, input logic fu,
                       input logic [31:0] wa, input logic [31:0] wt);
        vec_t v;
        v.pv = pv; v.paddr = pa; v.ptag = pt; v.laddr = la;
        v.bidle = bi; v.wend = we;
        v.e_ready = rdy; v.e_hit = hit; v.e_ltag = lt;
        v.e_wreq = wr; v.e_empty = em; v.e_full = fu;
        v.e_wbaddr = wa; v.e_wbtag = wt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pv, input logic [31:0] pa,
                         input logic [31:0] pt, input logic [31:0] la,
                         input logic bi, input logic we);
        push_valid    = pv;
        push_addr     = pa;
        push_data     = mkline(pt);
        lookup_addr   = la;
        bridge_idle_i = bi;
        axi_wend_i    = we;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input logic [31:0] la);
        chk({tag, " ready"}, LW'(push_ready), LW'(1'b1));
        chk({tag, " empty"}, LW'(empty), LW'(1'b1));
        chk({tag, " full"}, LW'(full), LW'(1'b0));
        chk({tag, " wreq"}, LW'(ca_wreq_o), LW'(1'b0));
        chk({tag, " hit"}, LW'(lookup_hit), LW'(1'b0));
        chk({tag, " ldata"}, lookup_data, '0);
        chk({tag, " wbaddr"}, LW'(wb_addr_o), '0);
        chk({tag, " wbdata"}, wb_data_o, '0);
        if (la == 0) chk({tag, " la"}, LW'(lookup_addr), '0);
    endtask

    initial begin
        //   pv paddr ptag laddr bi we | rdy hit ltag wr em fu wbaddr wbtag
        add(1, A0, D0, A5C, 1, 0,   1, 0, 0,  0, 1, 0, 0,  0);
        add(0, 0,  0,  A5C, 1, 0,   1, 1, D0, 1, 0, 0, A0, D0);
        add(0, 0,  0,  A5C, 1, 0,   1, 1, D0, 0, 0, 0, A0, D0);
        add(0, 0,  0,  A5C, 1, 1,   1, 1, D0, 0, 0, 0, A0, D0);
        add(0, 0,  0,  A5C, 0, 0,   1, 0, 0,  0, 1, 0, 0,  0);
        add(1, A1, D1, A1,  0, 0,   1, 0, 0,  0, 1, 0, 0,  0);
        add(1, A2, D2, A1,  0, 0,   1, 1, D1, 0, 0, 0, A1, D1);
        add(1, A3, D3, A2,  0, 0,   0, 1, D2, 0, 0, 1, A1, D1);
        add(1, A2, D4, A2,  0, 0,   1, 1, D2, 0, 0, 1, A1, D1);
        add(1, A3, D3, A2,  0, 0,   0, 1, D4, 0, 0, 1, A1, D1);
        add(1, A3, D3, A2,  1, 0,   0, 1, D4, 1, 0, 1, A1, D1);
        add(1, A3, D3, A2,  1, 1,   0, 1, D4, 0, 0, 1, A1, D1);
        add(1, A3, D3, A2,  1, 0,   1, 1, D4, 1, 0, 0, A2, D4);
        add(1, A2, D6, A3,  1, 0,   0, 1, D3, 0, 0, 1, A2, D4);
        add(0, 0,  0,  A3,  1, 1,   0, 1, D3, 0, 0, 1, A2, D4);
        add(0, 0,  0,  A3,  1, 0,   1, 1, D3, 1, 0, 0, A3, D3);
        add(1, A0, D5, A0,  1, 1,   1, 0, 0,  0, 0, 0, A3, D3);
        add(0, 0,  0,  A0,  1, 0,   1, 1, D5, 1, 0, 0, A0, D5);
        add(0, 0,  0,  A0,  1, 1,   1, 1, D5, 0, 0, 0, A0, D5);
        add(1, A1, D1, A1,  0, 0,   1, 0, 0,  0, 1, 0, 0,  0);
        add(0, 0,  0,  A1,  0, 1,   1, 1, D1, 0, 0, 0, A1, D1);
        add(0, 0,  0,  A1,  0, 0,   1, 1, D1, 0, 0, 0, A1, D1);

        rst = 1'b1;
        drive(0, 0, 0, A0, 0, 0);
        next_cycle();
        next_cycle();
        #3;
        chk_quiet("reset", A0);
        rst = 1'b0;
        next_cycle();

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("v%0d", i);
            drive(vecs[i].pv, vecs[i].paddr, vecs[i].ptag,
                  vecs[i].laddr, vecs[i].bidle, vecs[i].wend);
            #3;
            chk({t, " ready"}, LW'(push_ready), LW'(vecs[i].e_ready));
            chk({t, " hit"}, LW'(lookup_hit), LW'(vecs[i].e_hit));
            chk({t, " ldata"}, lookup_data, mkline(vecs[i].e_ltag));
            chk({t, " wreq"}, LW'(ca_wreq_o), LW'(vecs[i].e_wreq));
            chk({t, " empty"}, LW'(empty), LW'(vecs[i].e_empty));
            chk({t, " full"}, LW'(full), LW'(vecs[i].e_full));
            chk({t, " wbaddr"}, LW'(wb_addr_o), LW'(vecs[i].e_wbaddr));
            chk({t, " wbdata"}, wb_data_o, mkline(vecs[i].e_wbtag));
            next_cycle();
        end

        // Reset in WAIT with two entries resident.
        drive(1, A2, D2, A1, 1, 0);
        #3;
        chk("rw req", LW'(ca_wreq_o), LW'(1'b1));
        chk("rw ready", LW'(push_ready), LW'(1'b1));
        next_cycle();
        drive(0, 0, 0, A1, 1, 0);
        #3;
        chk("rw full", LW'(full), LW'(1'b1));
        chk("rw wreq0", LW'(ca_wreq_o), LW'(1'b0));
        chk("rw wbaddr", LW'(wb_addr_o), LW'(A1));
        rst = 1'b1;
        next_cycle();
        #3;
        chk_quiet("rst-wait", A1);
        rst = 1'b0;
        drive(0, 0, 0, A1, 0, 1);
        next_cycle();
        drive(0, 0, 0, A2, 1, 0);
        #3;
        chk_quiet("post-rst", A2);
        next_cycle();
        #3;
        chk("post-rst2 wreq", LW'(ca_wreq_o), LW'(1'b0));
        chk("post-rst2 empty", LW'(empty), LW'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
